mips_fetch_stage: RTL
=====================

// Module: mips_fetch_stage
// PURPOSE
//   Instruction-fetch (IF) stage feeding the IF/ID latch of the mipspipe 5-stage pipeline.
//   Owns the PC and fetches from an external instruction memory over a hold-until-valid handshake.
//   Honours a stall from the hazard unit and a redirect from branch resolution; inserts NOP bubbles.
// PARAMETERS
//   ADDR_W   32            PC / instruction-address width (bits)
//   RESET_PC 32'h00000000  PC loaded on reset
//   NOP      32'h00000020  bubble encoding (add r0,r0,r0) written into IF/ID IR
// PORTS
//   clock        in   1       single clock, all state on posedge
//   reset        in   1       asynchronous, active-high
//   stall        in   1       hazard unit: hold IF/ID and PC this cycle
//   redirect     in   1       branch/jump taken: refetch from redirect_pc
//   redirect_pc  in   ADDR_W  target; bits [1:0] ignored (forced 00)
//   imem_req     out  1       fetch request; once high, held until imem_rvalid
//   imem_addr    out  ADDR_W  fetch address; stable while imem_req high
//   imem_rdata   in   32      instruction word, valid when imem_rvalid
//   imem_rvalid  in   1       response; may be same cycle as imem_req (zero-wait)
//   ifid_ir      out  32      IF/ID.IR
//   ifid_pc4     out  ADDR_W  IF/ID.PC+4
//   ifid_valid   out  1       1 = ifid_ir is a real fetched instruction
// BEHAVIOUR
//   Reset (async): pc=RESET_PC, ifid_ir=NOP, ifid_pc4=0, ifid_valid=0, skid empty, state=RUN.
//     imem_req low for the reset cycle; first request asserted the first cycle after reset deasserts.
//   States: RUN (requesting pc), HOLD (word parked in 1-entry skid, no request),
//     DROP (draining stale outstanding access after redirect).
//   imem_req = (state==RUN || state==DROP); imem_addr = pc in RUN, stale addr in DROP.
//   Priority each cycle: redirect > stall > normal.
//   RUN, rvalid=1, no stall/redirect: ifid_ir<=rdata, ifid_pc4<=pc+4, ifid_valid<=1, pc<=pc+4.
//     Zero-wait memory gives 1 instr/cycle, latency 1 cycle req->IF/ID.
//   RUN, rvalid=0, no stall: ifid_ir<=NOP, ifid_valid<=0 (bubble); pc unchanged.
//   Stall: IF/ID and pc hold. RUN+rvalid during stall -> word to skid, pc<=pc+4, go HOLD.
//     RUN without rvalid during stall: request stays up (handshake never withdrawn).
//   HOLD, stall=0: skid -> IF/ID (valid=1, pc4 = captured pc+4), go RUN.
//   Redirect: ifid_ir<=NOP, ifid_valid<=0, skid cleared, pc<=redirect_pc&~3.
//     If imem_req high and rvalid=0 this cycle -> DROP, else RUN.
//   DROP: hold old addr until rvalid; discard data; -> RUN (fetch target next cycle).
//     Redirect in DROP: update pc, stay DROP. Stall in DROP: no effect on draining.
//   pc+4 wraps modulo 2^ADDR_W (0xFFFFFFFC -> 0x00000000), no error.
//   Reset mid-access: all state cleared immediately; outstanding response after reset ignored.
// CONFIGURATION
//   FETCH_STATS_EN defined: adds outputs fetch_count[31:0] (+1 per instr written to IF/ID with
//     valid=1) and bubble_count[31:0] (+1 per cycle ifid_valid<=0 while not stalled);
//     both reset to 0, wrap at 2^32. Undefined: ports and counters absent, no other change.
// TESTING
//   Zero-wait imem (rvalid tied 1), words 0x8C010000,0x8C020004.. at 0,4: after reset
//     ifid_ir = 0x8C010000/pc4=4 cycle 1, 0x8C020004/pc4=8 cycle 2, valid=1 throughout.
//   imem 2-cycle latency: ifid_valid pattern 0,0,1 repeating; imem_addr stable while req high.
//   stall=1 for 3 cycles while rvalid arrives: IF/ID frozen, state HOLD, imem_req=0; on release
//     held word appears next cycle, no word lost or duplicated.
//   redirect to 0x00000043 with access outstanding: next IF/ID = NOP/valid 0; stale rvalid
//     data dropped; next fetched addr 0x00000040.
//   RESET_PC=0xFFFFFFFC, zero-wait: ifid_pc4=0x00000000, next imem_addr=0x00000000.
//   Assert reset mid-stall-HOLD: outputs return to NOP/0/0 immediately; with FETCH_STATS_EN,
//     counters read 0; after 10 zero-wait fetches fetch_count=10, bubble_count=0.

Source files
------------

// File: rtl/mips_fetch_stage_if.sv
// Instruction-memory handshake between the fetch stage (master) and the imem (slave).
// Request is held until the matching rvalid; rvalid may arrive in the same cycle as the request.
interface mips_fetch_stage_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_rdata;
  logic              imem_rvalid;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rdata,
    input  imem_rvalid
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rdata,
    output imem_rvalid
  );
endinterface

// File: rtl/mips_fetch_stage.sv
// IF stage of the mipspipe 5-stage pipeline: owns the PC, fetches over a hold-until-valid
// handshake, parks a word in a 1-entry skid when stalled, and drains a stale access after a
// redirect. Optional macro FETCH_STATS_EN adds fetch_count/bubble_count outputs.
module mips_fetch_stage #(
  parameter int unsigned       ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [31:0]       NOP      = 32'h0000_0020
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                stall,
  input  logic                redirect,
  input  logic [ADDR_W-1:0]   redirect_pc,
  mips_fetch_stage_if.master  imem,
  output logic [31:0]         ifid_ir,
  output logic [ADDR_W-1:0]   ifid_pc4,
  output logic                ifid_valid
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0]         fetch_count,
  output logic [31:0]         bubble_count
`endif
);

  typedef enum logic [1:0] {StRun, StHold, StDrop} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] drop_addr_q, drop_addr_d;
  logic [31:0]       skid_ir_q, skid_ir_d;
  logic [ADDR_W-1:0] skid_pc4_q, skid_pc4_d;
  logic [31:0]       ir_q, ir_d;
  logic [ADDR_W-1:0] pc4_q, pc4_d;
  logic              valid_q, valid_d;
  logic              ifid_we;
  logic [ADDR_W-1:0] pc_plus4;
  logic [ADDR_W-1:0] target;

  assign pc_plus4 = pc_q + ADDR_W'(4);
  assign target   = {redirect_pc[ADDR_W-1:2], 2'b00};

  // Request is gated by reset so it stays low during the reset cycle itself.
  assign imem.imem_req  = ((state_q == StRun) || (state_q == StDrop)) && !reset;
  assign imem.imem_addr = (state_q == StDrop) ? drop_addr_q : pc_q;

  assign ifid_ir    = ir_q;
  assign ifid_pc4   = pc4_q;
  assign ifid_valid = valid_q;

  // Next-state: redirect beats stall beats normal flow.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    drop_addr_d = drop_addr_q;
    skid_ir_d   = skid_ir_q;
    skid_pc4_d  = skid_pc4_q;
    ir_d        = ir_q;
    pc4_d       = pc4_q;
    valid_d     = valid_q;
    ifid_we     = 1'b0;

    if (redirect) begin
      ifid_we    = 1'b1;
      ir_d       = NOP;
      valid_d    = 1'b0;
      skid_ir_d  = NOP;
      skid_pc4_d = '0;
      pc_d       = target;
      // An access still in flight must be drained before the target can be requested.
      if (imem.imem_req && !imem.imem_rvalid) begin
        state_d     = StDrop;
        drop_addr_d = imem.imem_addr;
      end else begin
        state_d = StRun;
      end
    end else begin
      unique case (state_q)
        StRun: begin
          if (stall) begin
            if (imem.imem_rvalid) begin
              skid_ir_d  = imem.imem_rdata;
              skid_pc4_d = pc_plus4;
              pc_d       = pc_plus4;
              state_d    = StHold;
            end
          end else begin
            ifid_we = 1'b1;
            if (imem.imem_rvalid) begin
              ir_d    = imem.imem_rdata;
              pc4_d   = pc_plus4;
              valid_d = 1'b1;
              pc_d    = pc_plus4;
            end else begin
              ir_d    = NOP;
              valid_d = 1'b0;
            end
          end
        end
        StHold: begin
          if (!stall) begin
            ifid_we = 1'b1;
            ir_d    = skid_ir_q;
            pc4_d   = skid_pc4_q;
            valid_d = 1'b1;
            state_d = StRun;
          end
        end
        StDrop: begin
          if (!stall) begin
            ifid_we = 1'b1;
            ir_d    = NOP;
            valid_d = 1'b0;
          end
          // Stale data is discarded; stall does not hold up the drain.
          if (imem.imem_rvalid) begin
            state_d = StRun;
          end
        end
        default: state_d = StRun;
      endcase
    end
  end

  // State and pipeline registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= StRun;
      pc_q        <= RESET_PC;
      drop_addr_q <= '0;
      skid_ir_q   <= NOP;
      skid_pc4_q  <= '0;
      ir_q        <= NOP;
      pc4_q       <= '0;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      drop_addr_q <= drop_addr_d;
      skid_ir_q   <= skid_ir_d;
      skid_pc4_q  <= skid_pc4_d;
      ir_q        <= ir_d;
      pc4_q       <= pc4_d;
      valid_q     <= valid_d;
    end
  end

`ifdef FETCH_STATS_EN
  logic [31:0] fetch_cnt_q, bubble_cnt_q;

  assign fetch_count  = fetch_cnt_q;
  assign bubble_count = bubble_cnt_q;

  // Count real instructions and unstalled bubbles written into IF/ID.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fetch_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      if (ifid_we && valid_d) begin
        fetch_cnt_q <= fetch_cnt_q + 32'd1;
      end
      if (ifid_we && !valid_d && !stall) begin
        bubble_cnt_q <= bubble_cnt_q + 32'd1;
      end
    end
  end
`endif

endmodule
